// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with saturating direction counters.
// Optional performance counters are enabled by BRANCH_TARGET_PREDICTOR_STATS_EN.
module branch_target_predictor #(
  parameter int ENTRIES       = 64,
  parameter int TAG_WIDTH     = 10,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] lookupAddress,
  output logic        branchPredictValid,
  output logic [31:0] branchPredictData,
  input  logic        updateValid,
  input  logic [31:0] updateAddress,
  input  logic        updateTaken,
  input  logic [31:0] updateTarget,
  input  logic        clearRequest,
  output logic        clearBusy,
  output logic [31:0] statLookups,
  output logic [31:0] statHits,
  output logic [31:0] statUpdates
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_WIDTH + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_WEAK =
    COUNTER_WIDTH'(1) << (COUNTER_WIDTH - 1);

  logic [ENTRIES-1:0]       validQ;
  logic [TAG_WIDTH-1:0]     tagQ     [ENTRIES];
  logic [31:0]              targetQ  [ENTRIES];
  logic [COUNTER_WIDTH-1:0] counterQ [ENTRIES];

  logic [0:0]       state;
  logic [IDX_W-1:0] walkIdx;

  logic [IDX_W-1:0]     lkIdx;
  logic [TAG_WIDTH-1:0] lkTag;
  logic                 lkHit;
  logic [IDX_W-1:0]     upIdx;
  logic [TAG_WIDTH-1:0] upTag;
  logic                 upHit;
  logic                 updateAccept;
  logic                 unusedPc;

  assign lkIdx = lookupAddress[IDX_W+1:2];
  assign lkTag = lookupAddress[TAG_HI:TAG_LO];
  assign lkHit = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);

  assign upIdx = updateAddress[IDX_W+1:2];
  assign upTag = updateAddress[TAG_HI:TAG_LO];
  assign upHit = validQ[upIdx] && (tagQ[upIdx] == upTag);

  assign unusedPc = ^{lookupAddress, updateAddress};

  // A clear request in the same cycle wins over the update
  assign updateAccept = reset && (state == IDLE) &&
                        !clearRequest && updateValid;

  assign branchPredictValid = reset && (state == IDLE) && lkHit &&
                              counterQ[lkIdx][COUNTER_WIDTH-1];
  assign branchPredictData  = branchPredictValid ? targetQ[lkIdx] : '0;
  assign clearBusy          = reset && (state == CLEARING);

  always_ff @(posedge clock) begin
    if (!reset) begin
      validQ  <= '0;
      state   <= IDLE;
      walkIdx <= '0;
    end else if (state == CLEARING) begin
      validQ[walkIdx] <= 1'b0;
      if (&walkIdx) begin
        state   <= IDLE;
        walkIdx <= '0;
      end else begin
        walkIdx <= walkIdx + 1'b1;
      end
    end else if (clearRequest) begin
      state <= CLEARING;
    end else if (updateAccept && (upHit || updateTaken)) begin
      validQ[upIdx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset so they can map onto RAM
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state == CLEARING) begin
        counterQ[walkIdx] <= '0;
      end else if (updateAccept) begin
        if (upHit) begin
          if (updateTaken) begin
            targetQ[upIdx] <= updateTarget;
            if (counterQ[upIdx] != CNT_MAX)
              counterQ[upIdx] <= counterQ[upIdx] + 1'b1;
          end else if (counterQ[upIdx] != '0) begin
            counterQ[upIdx] <= counterQ[upIdx] - 1'b1;
          end
        end else if (updateTaken) begin
          tagQ[upIdx]     <= upTag;
          targetQ[upIdx]  <= updateTarget;
          counterQ[upIdx] <= CNT_WEAK;
        end
      end
    end
  end

`ifdef BRANCH_TARGET_PREDICTOR_STATS_EN
  logic [31:0] lookupsQ;
  logic [31:0] hitsQ;
  logic [31:0] updatesQ;

  always_ff @(posedge clock) begin
    if (!reset) begin
      lookupsQ <= '0;
      hitsQ    <= '0;
      updatesQ <= '0;
    end else begin
      if ((state == IDLE) && (lookupsQ != '1))
        lookupsQ <= lookupsQ + 1'b1;
      if (branchPredictValid && (hitsQ != '1))
        hitsQ <= hitsQ + 1'b1;
      if (updateAccept && (updatesQ != '1))
        updatesQ <= updatesQ + 1'b1;
    end
  end

  assign statLookups = lookupsQ;
  assign statHits    = hitsQ;
  assign statUpdates = updatesQ;
`else
  assign statLookups = '0;
  assign statHits    = '0;
  assign statUpdates = '0;
`endif

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, number of direct-mapped entries; power of two, 4 to 1024.
REQ-002 Parameter TAG_WIDTH, default 10, stored tag bits per entry, 1 to 20.
REQ-003 Parameter COUNTER_WIDTH, default 2, saturating direction-counter bits, 1 to 4.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 lookupAddress  in  32  fetch PC to predict.
REQ-007 branchPredictValid  out  1  predict taken for lookupAddress.
REQ-008 branchPredictData  out  32  predicted target; 0 when branchPredictValid=0.
REQ-009 updateValid  in  1  resolved control-transfer report from execute.
REQ-010 updateAddress  in  32  PC of resolved instruction.
REQ-011 updateTaken  in  1  resolved direction.
REQ-012 updateTarget  in  32  resolved target.
REQ-013 clearRequest  in  1  one-cycle pulse; invalidate all entries.
REQ-014 clearBusy  out  1  clear walk in progress.
REQ-015 statLookups, statHits, statUpdates  out  32 each  performance counters.

Function
REQ-016 Index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = PC[IDX_W+TAG_WIDTH+1:IDX_W+2]; PC[1:0] ignored.
REQ-017 Entry: valid bit, tag, 32-bit target, COUNTER_WIDTH-bit counter.
REQ-018 Lookup is combinational from registered state (zero-cycle latency): hit = valid and tag match; branchPredictValid = hit and counter MSB=1, and clearBusy=0.
REQ-019 Update hit: updateTaken=1 increments counter saturating at all-ones and writes updateTarget; updateTaken=0 decrements saturating at 0, target unchanged.
REQ-020 Update miss with updateTaken=1: allocate/overwrite entry; valid=1, new tag, target=updateTarget, counter=weakly taken (MSB=1, others 0).
REQ-021 Update miss with updateTaken=0: no state change.
REQ-022 Update takes effect at the next edge; same-cycle lookup of the same index sees pre-update contents (no bypass).
REQ-023 State machine IDLE/CLEARING: clearRequest in IDLE -> CLEARING, walk index 0..ENTRIES-1 one entry per cycle writing valid=0, counter=0; after last index -> IDLE. Busy for exactly ENTRIES cycles.
REQ-024 In CLEARING: clearBusy=1, predictions suppressed, updateValid ignored (dropped), further clearRequest ignored.
REQ-025 clearRequest and updateValid in same IDLE cycle: clear wins, update dropped.

Reset
REQ-026 reset=0 at an edge: all valid bits 0, state IDLE, walk index 0, stat counters 0; clears take effect that edge regardless of CLEARING.
REQ-027 While reset=0: branchPredictValid=0, branchPredictData=0, clearBusy=0; updates and clearRequest ignored.
REQ-028 Targets/tags/counters need not be reset (RAM-inferable); valid bits only.

Configuration
REQ-029 Macro BRANCH_TARGET_PREDICTOR_STATS_EN defined: statLookups +1 per non-reset cycle outside CLEARING, statHits +1 per cycle branchPredictValid=1, statUpdates +1 per accepted update; all saturate at 0xFFFFFFFF.
REQ-030 Macro undefined: no counter flops; all three stat outputs tied to 0.

Verification
REQ-031 After reset, lookupAddress=0x100 -> branchPredictValid=0, branchPredictData=0.
REQ-032 Update 0x100 taken target 0x200, next cycle lookup 0x100 -> valid=1, data=0x200; lookup 0x104 -> valid=0.
REQ-033 ENTRIES=64: after REQ-032 entry, update 0x100 not-taken once -> valid=0 (counter 01); two taken updates -> counter 11; three not-taken -> counter 00, no underflow.
REQ-034 Alias: train 0x100, then update 0x10100 (same index, different tag) taken target 0x300 -> lookup 0x100 miss, lookup 0x10100 -> 0x300.
REQ-035 clearRequest pulse with trained entries plus concurrent updateValid -> clearBusy high exactly 64 cycles, update dropped, all lookups miss afterwards.
REQ-036 With STATS_EN: 10 lookup cycles, 3 hits, 2 updates -> statLookups=10, statHits=3, statUpdates=2; without macro all 0.
